calculation_seq: RTL



---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_mod_iter.sv | 95 +++++++++
 rtl/calculation_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the sequential six-result arithmetic block.
//   calc_state_t : top-level control state (IDLE, CALC, DONE)
//   DEFAULT_BW   : default operand/result width
//   clog2()      : width of the remainder-unit iteration counter
package calc_pkg;

  localparam int DEFAULT_BW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } calc_state_t;

  // Smallest r with 2**r >= value; a counter of this width reaches value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_mod_iter.sv
// Iterative restoring remainder unit: one quotient bit per clock.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse that captures dividend/divisor
//   dividend  : BW-bit dividend
//   divisor   : BW-bit divisor (zero is a defined case)
//   done      : one-cycle pulse after the last of BW iterations
//   remainder : dividend % divisor, or dividend when divisor == 0
//   div_zero  : captured divisor was zero
module calc_mod_iter
  import calc_pkg::*;
#(
  parameter int BW = DEFAULT_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          done,
  output logic [BW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = clog2(BW);
  localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic          busy_r;
  logic          done_r;
  logic [CW-1:0] cnt_r;
  logic [BW-1:0] dvd_r;   // dividend bits shift out the top, quotient bits shift in
  logic [BW-1:0] dsr_r;
  logic [BW-1:0] rem_r;
  logic          dz_r;

  logic [BW:0]   rem_shift_s;
  logic          sub_ok_s;
  logic [BW:0]   rem_next_s;

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  // With a zero divisor the subtraction is suppressed, so after BW steps the
  // remainder register holds the dividend itself.
  always_comb begin
    rem_shift_s = {rem_r, dvd_r[BW-1]};
    sub_ok_s    = 1'b0;
    rem_next_s  = rem_shift_s;
    if (!dz_r && (rem_shift_s >= {1'b0, dsr_r})) begin
      sub_ok_s   = 1'b1;
      rem_next_s = rem_shift_s - {1'b0, dsr_r};
    end else begin
      sub_ok_s   = 1'b0;
      rem_next_s = rem_shift_s;
    end
  end

  // Operand capture, iteration sequencing and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      dvd_r  <= {BW{1'b0}};
      dsr_r  <= {BW{1'b0}};
      rem_r  <= {BW{1'b0}};
      dz_r   <= 1'b0;
    end else if (start) begin
      busy_r <= 1'b1;
      done_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      dvd_r  <= dividend;
      dsr_r  <= divisor;
      rem_r  <= {BW{1'b0}};
      dz_r   <= (divisor == {BW{1'b0}});
    end else if (busy_r) begin
      // Remainder is always below the divisor, so the low BW bits are exact.
      rem_r <= rem_next_s[BW-1:0];
      dvd_r <= {dvd_r[BW-2:0], sub_ok_s};
      if (cnt_r == LAST_CNT) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done      = done_r;
  assign remainder = rem_r;
  assign div_zero  = dz_r;

endmodule

// File: rtl/calculation_seq.sv
// Handshaked six-result arithmetic block with an iterative modulo.
//   s1 = a + b            s2 = a * b           s3 = (a % b) + d
//   s4 = c + d + a*b      s5 = a - b           s6 = (b+1)*a + d + c - b
// All results wrap mod 2**BW; b == 0 gives a % b = a and div_zero = 1.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, c, d)
//   out_valid, out_ready: result handshake (s1..s6, div_zero)
module calculation_seq
  import calc_pkg::*;
#(
  parameter int BW = DEFAULT_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] c,
  input  logic [BW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] s1,
  output logic [BW-1:0] s2,
  output logic [BW-1:0] s3,
  output logic [BW-1:0] s4,
  output logic [BW-1:0] s5,
  output logic [BW-1:0] s6,
  output logic          div_zero
);

  localparam logic [BW-1:0] ONE_V = {{(BW-1){1'b0}}, 1'b1};

  calc_state_t   state_r;
  calc_state_t   state_next_s;
  logic          accept_s;
  logic          load_s;

  logic [BW-1:0] a_r, b_r, c_r, d_r;
  logic [BW-1:0] s1_r, s2_r, s3_r, s4_r, s5_r, s6_r;
  logic          div_zero_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic          mod_done_s;
  logic [BW-1:0] mod_rem_s;
  logic          mod_dz_s;

  logic [BW-1:0] prod_ab_s;
  logic [BW-1:0] b_inc_s;
  logic [BW-1:0] s1_s, s2_s, s3_s, s4_s, s5_s, s6_s;

  // The remainder unit captures a and b straight from the ports on the
  // accept edge, so its BW iterations start on the very next edge.
  calc_mod_iter #(
    .BW(BW)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .start    (accept_s),
    .dividend (a),
    .divisor  (b),
    .done     (mod_done_s),
    .remainder(mod_rem_s),
    .div_zero (mod_dz_s)
  );

  // Non-modulo results from the held operands; all intermediates wrap at BW bits.
  always_comb begin
    prod_ab_s = a_r * b_r;
    b_inc_s   = b_r + ONE_V;
    s1_s      = a_r + b_r;
    s2_s      = prod_ab_s;
    s3_s      = mod_rem_s + d_r;
    s4_s      = c_r + d_r + prod_ab_s;
    s5_s      = a_r - b_r;
    s6_s      = (b_inc_s * a_r) + d_r + c_r - b_r;
  end

  // Next-state logic with accept and result-load strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = CALC;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (mod_done_s) begin
          state_next_s = DONE;
          load_s       = 1'b1;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, operand and result registers; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= {BW{1'b0}};
      b_r         <= {BW{1'b0}};
      c_r         <= {BW{1'b0}};
      d_r         <= {BW{1'b0}};
      s1_r        <= {BW{1'b0}};
      s2_r        <= {BW{1'b0}};
      s3_r        <= {BW{1'b0}};
      s4_r        <= {BW{1'b0}};
      s5_r        <= {BW{1'b0}};
      s6_r        <= {BW{1'b0}};
      div_zero_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      if (accept_s) begin
        a_r <= a;
        b_r <= b;
        c_r <= c;
        d_r <= d;
      end
      // Results are only replaced on load, so they persist after the handshake.
      if (load_s) begin
        s1_r       <= s1_s;
        s2_r       <= s2_s;
        s3_r       <= s3_s;
        s4_r       <= s4_s;
        s5_r       <= s5_s;
        s6_r       <= s6_s;
        div_zero_r <= mod_dz_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s1        = s1_r;
  assign s2        = s2_r;
  assign s3        = s3_r;
  assign s4        = s4_r;
  assign s5        = s5_r;
  assign s6        = s6_r;
  assign div_zero  = div_zero_r;

endmodule
